alu_op_sequencer: RTL



---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_result_qual.sv | 40 ++++
 rtl/alu_op_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: ALU command codes,
// error bit positions and the sequencer FSM state type.
// No logic; imported by alu_result_qual and alu_op_sequencer.
package alu_pkg;

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_SUB = 4'd1;
  localparam logic [3:0] CMD_MUL = 4'd2;
  localparam logic [3:0] CMD_DIV = 4'd3;
  localparam logic [3:0] CMD_MOD = 4'd4;

  // Bit positions inside the 2-bit error vector {div_zero, overflow}.
  localparam int ERR_DZ  = 1;
  localparam int ERR_OVF = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_result_qual.sv
// Qualifies raw ALU output by command: zero-extends 16-bit results, masks flags.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of the command and ALU outputs.
// Ports: cmd (4) command in flight; alu_result (32) / alu_error (2) raw ALU outputs;
//        q_result (32) / q_err (2) qualified result and {div_zero, overflow}.
module alu_result_qual
  import alu_pkg::*;
(
  input  logic [3:0]  cmd,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_error,
  output logic [31:0] q_result,
  output logic [1:0]  q_err
);

  always_comb begin
    q_result = '0;
    q_err    = '0;
    case (cmd)
      CMD_ADD, CMD_SUB: begin
        // Upper ALU bits are not trusted for 16-bit operations.
        q_result       = {16'b0, alu_result[15:0]};
        q_err[ERR_OVF] = alu_error[ERR_OVF];
      end
      CMD_MUL: begin
        // The ALU flags B==0 for every command; only div/mod may report it.
        q_result = alu_result;
      end
      CMD_DIV, CMD_MOD: begin
        q_result      = {16'b0, alu_result[15:0]};
        q_err[ERR_DZ] = alu_error[ERR_DZ];
      end
      default: begin
        q_result = '0;
        q_err    = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer in front of a combinational ALU: launches registered operands, waits
// SETTLE_CYCLES edges, then captures a qualified result (optionally into acc).
// Latency: out_valid rises SETTLE_CYCLES edges after accept; one op per SETTLE_CYCLES+2 cycles.
// Backpressure: result is held stable in HOLD until out_ready; no request accepted until then.
// Ports: clk/rst (async active-high); in_* request with valid/ready; alu_a/alu_b/alu_cmd
//        registered ALU drive; alu_result/alu_error from ALU; out_* result with valid/ready;
//        acc 32-bit accumulator.
// Optional: ALU_SEQ_STICKY_ERR_EN adds clr_err input and err_sticky (2) output.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cmd,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_use_acc,
  input  logic        in_wr_acc,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_cmd,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [1:0]  out_err,
  output logic [31:0] acc
`ifdef ALU_SEQ_STICKY_ERR_EN
  ,
  input  logic        clr_err,
  output logic [1:0]  err_sticky
`endif
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      alu_a_q, alu_a_d;
  logic [15:0]      alu_b_q, alu_b_d;
  logic [3:0]       alu_cmd_q, alu_cmd_d;
  logic             wr_acc_q, wr_acc_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [1:0]       out_err_q, out_err_d;
  logic [31:0]      acc_q, acc_d;
  logic             capture;

  logic [31:0]      q_result;
  logic [1:0]       q_err;

  alu_result_qual u_qual (
    .cmd        (alu_cmd_q),
    .alu_result (alu_result),
    .alu_error  (alu_error),
    .q_result   (q_result),
    .q_err      (q_err)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cmd_d    = alu_cmd_q;
    wr_acc_d     = wr_acc_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    acc_d        = acc_q;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          alu_a_d    = in_use_acc ? acc_q[15:0] : in_a;
          alu_b_d    = in_b;
          alu_cmd_d  = in_cmd;
          wr_acc_d   = in_wr_acc;
          cnt_d      = CNT_W'(SETTLE_CYCLES - 1);
          in_ready_d = 1'b0;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          capture      = 1'b1;
          out_result_d = q_result;
          out_err_d    = q_err;
          if (wr_acc_q) acc_d = q_result;
          out_valid_d  = 1'b1;
          state_d      = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        // in_ready comes back one cycle after the result handshake.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

`ifdef ALU_SEQ_STICKY_ERR_EN
  logic [1:0] err_sticky_q, err_sticky_d;

  // A capture in the same cycle as clr_err still sets its new bits.
  always_comb begin
    err_sticky_d = clr_err ? 2'b00 : err_sticky_q;
    if (capture) err_sticky_d = err_sticky_d | q_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_sticky_q <= '0;
    else     err_sticky_q <= err_sticky_d;
  end

  assign err_sticky = err_sticky_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cmd_q    <= '0;
      wr_acc_q     <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_err_q    <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cmd_q    <= alu_cmd_d;
      wr_acc_q     <= wr_acc_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
      acc_q        <= acc_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cmd    = alu_cmd_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;
  assign acc        = acc_q;

endmodule
